// File: rtl/jtdsp16_pio_host_if.sv
// Host-side bus of the DSP16 parallel I/O bridge.
// The host queues words for the DSP and drains words the DSP wrote.
interface jtdsp16_pio_host_if;
    logic [15:0] host_din;
    logic        host_wr;
    logic        host_sel;
    logic [1:0]  host_full;
    logic [15:0] host_dout;
    logic        host_dsel;
    logic        host_dvalid;
    logic        host_drd;
    logic [1:0]  err;
    logic        err_clr;

    modport master (
        output host_din, host_wr, host_sel,
        output host_drd, err_clr,
        input  host_full, host_dout, host_dsel,
        input  host_dvalid, err
    );

    modport slave (
        input  host_din, host_wr, host_sel,
        input  host_drd, err_clr,
        output host_full, host_dout, host_dsel,
        output host_dvalid, err
    );
endinterface

// File: rtl/jtdsp16_pio_host.sv
// Host bridge for the DSP16 parallel port: two host->DSP FIFOs
// served on pids_n, and a 2-entry DSP->host queue filled on pods_n.
module jtdsp16_pio_host #(
    parameter int AW     = 2,
    parameter int IRQ_EN = 1
) (
    input  logic        rst,
    input  logic        clk,
    input  logic        cen,
    jtdsp16_pio_host_if.slave hif,
    output logic [15:0] pbus_in,
    input  logic [15:0] pbus_out,
    input  logic        pods_n,
    input  logic        pids_n,
    input  logic        psel,
    output logic        irq
);
    localparam int DEPTH = 1 << AW;
    localparam bit IRQ_ON = (IRQ_EN != 0);

    logic [15:0]   mem_q  [2][DEPTH];
    logic [15:0]   mem_d  [2][DEPTH];
    logic [AW-1:0] wp_q   [2];
    logic [AW-1:0] wp_d   [2];
    logic [AW-1:0] rp_q   [2];
    logic [AW-1:0] rp_d   [2];
    logic [AW:0]   cnt_q  [2];
    logic [AW:0]   cnt_d  [2];
    logic [15:0]   hold_q [2];
    logic [15:0]   hold_d [2];
    logic [16:0]   oq_q   [2];
    logic [16:0]   oq_d   [2];
    logic [1:0]    ocnt_q, ocnt_d;
    logic [1:0]    err_q, err_d;
    logic          irq_q, irq_d;
    logic          last_pods_q, last_pods_d;
    logic          last_pids_q, last_pids_d;

    logic          pods_rise, pids_rise, opop, ovf;
    logic [1:0]    full, empty, push, pop, udf;

    assign pods_rise = cen & pods_n & ~last_pods_q;
    assign pids_rise = cen & pids_n & ~last_pids_q;
    assign opop      = cen & hif.host_drd & (ocnt_q != 2'd0);

    always_comb begin
        full  = '0;
        empty = '0;
        push  = '0;
        pop   = '0;
        udf   = '0;
        for (int n = 0; n < 2; n++) begin
            full[n]  = cnt_q[n][AW];
            empty[n] = (cnt_q[n] == '0);
            push[n]  = cen & hif.host_wr
                     & (hif.host_sel == n[0]) & ~full[n];
            pop[n]   = pids_rise & (psel == n[0]) & ~empty[n];
            udf[n]   = pids_rise & (psel == n[0]) & empty[n];
        end
    end

    always_comb begin
        mem_d  = mem_q;
        wp_d   = wp_q;
        rp_d   = rp_q;
        cnt_d  = cnt_q;
        hold_d = hold_q;
        for (int n = 0; n < 2; n++) begin
            if (push[n]) begin
                mem_d[n][wp_q[n]] = hif.host_din;
                wp_d[n] = wp_q[n] + AW'(1);
            end
            if (pop[n]) begin
                hold_d[n] = mem_q[n][rp_q[n]];
                rp_d[n]   = rp_q[n] + AW'(1);
            end
            cnt_d[n] = cnt_q[n] + (AW+1)'(push[n])
                     - (AW+1)'(pop[n]);
        end
    end

    // Host pop goes first so a full queue can still take the new word
    always_comb begin
        oq_d   = oq_q;
        ocnt_d = ocnt_q;
        ovf    = 1'b0;
        if (opop) begin
            oq_d[0] = oq_q[1];
            ocnt_d  = ocnt_q - 2'd1;
        end
        if (pods_rise) begin
            if (ocnt_d == 2'd2) begin
                ovf = 1'b1;
            end else begin
                oq_d[ocnt_d[0]] = {psel, pbus_out};
                ocnt_d = ocnt_d + 2'd1;
            end
        end
    end

    always_comb begin
        err_d = err_q;
        if (cen & hif.err_clr) err_d = 2'b00;
        err_d = err_d | {ovf, |udf};
        irq_d = irq_q;
        if (cen)
            irq_d = IRQ_ON & ((cnt_d[0] != '0) | (cnt_d[1] != '0));
        last_pods_d = cen ? pods_n : last_pods_q;
        last_pids_d = cen ? pids_n : last_pids_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q       <= '{default: '0};
            wp_q        <= '{default: '0};
            rp_q        <= '{default: '0};
            cnt_q       <= '{default: '0};
            hold_q      <= '{default: '0};
            oq_q        <= '{default: '0};
            ocnt_q      <= 2'd0;
            err_q       <= 2'b00;
            irq_q       <= 1'b0;
            last_pods_q <= 1'b1;
            last_pids_q <= 1'b1;
        end else begin
            mem_q       <= mem_d;
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            oq_q        <= oq_d;
            ocnt_q      <= ocnt_d;
            err_q       <= err_d;
            irq_q       <= irq_d;
            last_pods_q <= last_pods_d;
            last_pids_q <= last_pids_d;
        end
    end

    assign pbus_in = empty[psel] ? hold_q[psel]
                                 : mem_q[psel][rp_q[psel]];

    assign hif.host_full   = full;
    assign hif.host_dout   = oq_q[0][15:0];
    assign hif.host_dsel   = oq_q[0][16];
    assign hif.host_dvalid = (ocnt_q != 2'd0);
    assign hif.err         = err_q;
    assign irq             = irq_q;
endmodule

// File: tb/tb_jtdsp16_pio_host.sv
// Bench for jtdsp16_pio_host: queue-based model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_jtdsp16_pio_host;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cen = 1'b1;
    logic [15:0] pbus_in;
    logic [15:0] pbus_out = '0;
    logic        pods_n = 1'b1;
    logic        pids_n = 1'b1;
    logic        psel = 1'b0;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    jtdsp16_pio_host_if hif ();

    jtdsp16_pio_host #(.AW(2), .IRQ_EN(1)) dut (
        .rst(rst), .clk(clk), .cen(cen), .hif(hif),
        .pbus_in(pbus_in), .pbus_out(pbus_out),
        .pods_n(pods_n), .pids_n(pids_n),
        .psel(psel), .irq(irq)
    );

    always #5 clk = ~clk;

    // Behavioural model
    logic [15:0] mq0[$];
    logic [15:0] mq1[$];
    logic [16:0] moq[$];
    logic [15:0] mhold0 = '0;
    logic [15:0] mhold1 = '0;
    logic [1:0]  merr = '0;
    logic        mirq = 1'b0;
    logic        mlast_o = 1'b1;
    logic        mlast_i = 1'b1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq0.delete(); mq1.delete(); moq.delete();
            mhold0 = '0; mhold1 = '0; merr = '0; mirq = 1'b0;
            mlast_o = 1'b1; mlast_i = 1'b1;
        end else if (cen) begin
            bit ri, ro, f0, f1, u, o;
            ri = pids_n && !mlast_i;
            ro = pods_n && !mlast_o;
            mlast_i = pids_n;
            mlast_o = pods_n;
            f0 = (mq0.size() == 4);
            f1 = (mq1.size() == 4);
            u = 0; o = 0;
            if (ri) begin
                if (psel == 0) begin
                    if (mq0.size() == 0) u = 1;
                    else mhold0 = mq0.pop_front();
                end else begin
                    if (mq1.size() == 0) u = 1;
                    else mhold1 = mq1.pop_front();
                end
            end
            if (hif.host_wr) begin
                if (hif.host_sel == 0 && !f0) mq0.push_back(hif.host_din);
                if (hif.host_sel == 1 && !f1) mq1.push_back(hif.host_din);
            end
            if (hif.host_drd && moq.size() > 0) void'(moq.pop_front());
            if (ro) begin
                if (moq.size() < 2) moq.push_back({psel, pbus_out});
                else o = 1;
            end
            if (hif.err_clr) merr = '0;
            merr = merr | {o, u};
            mirq = (mq0.size() != 0) || (mq1.size() != 0);
        end
    end

    function automatic logic [15:0] m_pbus();
        if (psel == 0) return (mq0.size() != 0) ? mq0[0] : mhold0;
        return (mq1.size() != 0) ? mq1[0] : mhold1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("m_pbus_in", 32'(pbus_in), 32'(m_pbus()));
        chk("m_full", 32'(hif.host_full),
            32'({mq1.size() == 4, mq0.size() == 4}));
        chk("m_dvalid", 32'(hif.host_dvalid), 32'(moq.size() != 0));
        if (moq.size() != 0) begin
            chk("m_dout", 32'(hif.host_dout), 32'(moq[0][15:0]));
            chk("m_dsel", 32'(hif.host_dsel), 32'(moq[0][16]));
        end
        chk("m_err", 32'(hif.err), 32'(merr));
        chk("m_irq", 32'(irq), 32'(mirq));
    end

    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic host_push(input logic sel, input logic [15:0] d);
        hif.host_wr = 1'b1; hif.host_sel = sel; hif.host_din = d;
        cycle();
        hif.host_wr = 1'b0;
    endtask

    task automatic pid_pulse();
        pids_n = 1'b0; cycle(); cycle();
        pids_n = 1'b1; cycle();
    endtask

    task automatic dsp_wr(input logic sel, input logic [15:0] d);
        psel = sel; pbus_out = d;
        pods_n = 1'b0; cycle();
        pods_n = 1'b1; cycle();
    endtask

    initial begin
        hif.host_din = '0; hif.host_wr = 1'b0; hif.host_sel = 1'b0;
        hif.host_drd = 1'b0; hif.err_clr = 1'b0;
        repeat (3) cycle();
        chk("rst_pbus", 32'(pbus_in), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_full", 32'(hif.host_full), 32'h0);
        chk("rst_dvalid", 32'(hif.host_dvalid), 32'h0);
        chk("rst_dout", 32'(hif.host_dout), 32'h0);
        chk("rst_err", 32'(hif.err), 32'h0);
        rst = 1'b0;
        cycle();

        host_push(0, 16'h1234);
        chk("lat_pbus", 32'(pbus_in), 32'h1234);
        chk("lat_irq", 32'(irq), 32'h1);
        host_push(0, 16'h5678);
        pid_pulse();
        chk("pop1", 32'(pbus_in), 32'h5678);
        pid_pulse();
        chk("hold0", 32'(pbus_in), 32'h5678);
        chk("irq_off", 32'(irq), 32'h0);

        for (int i = 0; i < 4; i++) host_push(1, 16'h1001 + 16'(i));
        chk("full1", 32'(hif.host_full), 32'h2);
        host_push(1, 16'h1005);
        chk("full1b", 32'(hif.host_full), 32'h2);
        psel = 1'b1;
        cycle();
        for (int i = 0; i < 4; i++) begin
            chk("ch1_order", 32'(pbus_in), 32'h1001 + i);
            pid_pulse();
        end
        chk("ch1_hold", 32'(pbus_in), 32'h1004);
        chk("ch1_irq", 32'(irq), 32'h0);

        psel = 1'b0;
        pid_pulse();
        chk("udf_err", 32'(hif.err), 32'h1);
        chk("udf_pbus", 32'(pbus_in), 32'h5678);
        hif.err_clr = 1'b1; cycle(); hif.err_clr = 1'b0;
        chk("err_clr", 32'(hif.err), 32'h0);

        dsp_wr(0, 16'hAAAA);
        chk("oq_valid", 32'(hif.host_dvalid), 32'h1);
        chk("oq_head", 32'({hif.host_dsel, hif.host_dout}), 32'h0AAAA);
        dsp_wr(1, 16'hBBBB);
        dsp_wr(0, 16'hCCCC);
        chk("ovf_err", 32'(hif.err), 32'h2);
        chk("ovf_head", 32'({hif.host_dsel, hif.host_dout}), 32'h0AAAA);
        psel = 1'b0; pbus_out = 16'hCCCC;
        pods_n = 1'b0; cycle();
        pods_n = 1'b1; hif.host_drd = 1'b1; cycle();
        hif.host_drd = 1'b0;
        chk("rdwr_err", 32'(hif.err), 32'h2);
        chk("rdwr_head", 32'({hif.host_dsel, hif.host_dout}), 32'h1BBBB);
        hif.host_drd = 1'b1; cycle();
        chk("rdwr_2nd", 32'({hif.host_dsel, hif.host_dout}), 32'h0CCCC);
        cycle();
        hif.host_drd = 1'b0;
        chk("oq_empty", 32'(hif.host_dvalid), 32'h0);
        hif.err_clr = 1'b1; cycle(); hif.err_clr = 1'b0;

        host_push(0, 16'h2001);
        host_push(0, 16'h2002);
        pids_n = 1'b0; cycle();
        pids_n = 1'b1;
        hif.host_wr = 1'b1; hif.host_sel = 1'b0; hif.host_din = 16'h2003;
        cycle();
        hif.host_wr = 1'b0;
        chk("pp_head", 32'(pbus_in), 32'h2002);
        pid_pulse();
        chk("pp_next", 32'(pbus_in), 32'h2003);
        pid_pulse();
        chk("pp_hold", 32'(pbus_in), 32'h2003);
        chk("pp_irq", 32'(irq), 32'h0);

        host_push(0, 16'h3001);
        cen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pids_n = 1'b0; pods_n = 1'b0;
            hif.host_wr = 1'b1; hif.host_din = 16'hDEAD;
            cycle();
            pids_n = 1'b1; pods_n = 1'b1;
            cycle();
        end
        hif.host_wr = 1'b0;
        psel = 1'b1; cycle();
        chk("cen_psel1", 32'(pbus_in), 32'h1004);
        psel = 1'b0; cycle();
        chk("cen_psel0", 32'(pbus_in), 32'h3001);
        chk("cen_nocap", 32'(hif.host_dvalid), 32'h0);
        cen = 1'b1; cycle();
        chk("cen_back", 32'(pbus_in), 32'h3001);

        pids_n = 1'b0; cycle();
        rst = 1'b1; #1;
        chk("mrst_pbus", 32'(pbus_in), 32'h0);
        chk("mrst_irq", 32'(irq), 32'h0);
        chk("mrst_full", 32'(hif.host_full), 32'h0);
        chk("mrst_err", 32'(hif.err), 32'h0);
        cycle();
        rst = 1'b0; cycle();
        pids_n = 1'b1; cycle();
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
